// File: rtl/lifting_seq_ctrl.sv
// Frame sequencer for the DWT lifting predictor: counts samples, drives per-sample
// predictor controls, inserts one zero-extension flush cycle, then reports completion.
module lifting_seq_ctrl #(
  parameter int LEN_W = 12,
  parameter int FRM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             cfg_internal,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             valid_in,
  output logic             internal_valid,
  output logic             iseven,
  output logic             valid_detailOut,
  output logic             zero_sel,
  output logic             busy,
  output logic             done,
  output logic             frame_err,
  output logic [FRM_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_nxt;
  logic [LEN_W-1:0] len_q;
  logic             internal_q;
  logic             accept;
  logic             len_ok;
  logic             start_ok;
  logic             frame_err_nxt;

  // Even and non-zero is the same as even and >= 2.
  assign len_ok   = (frame_len[0] == 1'b0) && (frame_len != '0);
  assign start_ok = (state == IDLE) && start && len_ok;

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    in_ready        = 1'b0;
    accept          = 1'b0;
    iseven          = 1'b0;
    valid_in        = 1'b0;
    internal_valid  = 1'b0;
    valid_detailOut = 1'b0;
    zero_sel        = 1'b0;
    frame_err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (start) begin
          if (len_ok) state_nxt = RUN;
          else        frame_err_nxt = 1'b1;
        end
      end
      RUN: begin
        in_ready        = 1'b1;
        accept          = in_valid;
        iseven          = ~cnt[0];
        valid_in        = accept & ~internal_q;
        internal_valid  = accept & internal_q;
        // An even sample (other than the first) closes the previous odd/even pair.
        valid_detailOut = accept & ~cnt[0] & (cnt != '0);
        if (accept) begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == len_q - 1'b1) state_nxt = FLUSH;
        end else begin
          // The predictor drops its pipeline on an idle cycle, so a bubble kills the frame.
          frame_err_nxt = 1'b1;
          state_nxt     = IDLE;
        end
      end
      FLUSH: begin
        valid_detailOut = 1'b1;
        zero_sel        = 1'b1;
        state_nxt       = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q      <= '0;
      internal_q <= 1'b0;
    end else if (start_ok) begin
      len_q      <= frame_len;
      internal_q <= cfg_internal;
    end
  end

  // done and the incremented count appear together in the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      busy      <= (state_nxt != IDLE);
      done      <= (state == FLUSH);
      frame_err <= frame_err_nxt;
      if (state == FLUSH) frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_lifting_seq_ctrl.sv
// Directed bench for lifting_seq_ctrl: nominal, bad length, bubble abort, internal
// source, start-while-busy, mid-frame reset and frame counter wrap.
module tb_lifting_seq_ctrl;
  localparam int LEN_W = 12;
  localparam int FRM_W = 2;

  logic             clk;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] frame_len;
  logic             cfg_internal;
  logic             in_valid;
  logic             in_ready;
  logic             valid_in;
  logic             internal_valid;
  logic             iseven;
  logic             valid_detailOut;
  logic             zero_sel;
  logic             busy;
  logic             done;
  logic             frame_err;
  logic [FRM_W-1:0] frame_cnt;

  int checks;
  int errors;

  lifting_seq_ctrl #(.LEN_W(LEN_W), .FRM_W(FRM_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .frame_len      (frame_len),
    .cfg_internal   (cfg_internal),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .valid_in       (valid_in),
    .internal_valid (internal_valid),
    .iseven         (iseven),
    .valid_detailOut(valid_detailOut),
    .zero_sel       (zero_sel),
    .busy           (busy),
    .done           (done),
    .frame_err      (frame_err),
    .frame_cnt      (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, ".valid_in"}, 32'(valid_in), 32'd0);
    chk({tag, ".internal_valid"}, 32'(internal_valid), 32'd0);
    chk({tag, ".iseven"}, 32'(iseven), 32'd0);
    chk({tag, ".valid_detailOut"}, 32'(valid_detailOut), 32'd0);
    chk({tag, ".zero_sel"}, 32'(zero_sel), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".frame_err"}, 32'(frame_err), 32'd0);
    chk({tag, ".frame_cnt"}, 32'(frame_cnt), 32'd0);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    start        = 1'b0;
    frame_len    = '0;
    cfg_internal = 1'b0;
    in_valid     = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Runs one complete frame; start_at >= 0 pulses an ignored start (len=2) on that sample.
  task automatic run_frame(input int len, input bit internal, input int exp_cnt, input int start_at);
    int strobes;
    strobes      = 0;
    start        = 1'b1;
    frame_len    = LEN_W'(len);
    cfg_internal = internal;
    in_valid     = 1'b0;
    tick();
    start = 1'b0;
    chk("frm.in_ready_after_start", 32'(in_ready), 32'd1);
    chk("frm.busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < len; i++) begin
      in_valid     = 1'b1;
      cfg_internal = ~internal;
      if (i == start_at) begin
        start     = 1'b1;
        frame_len = LEN_W'(2);
      end
      #1;
      chk($sformatf("frm.iseven[%0d]", i), 32'(iseven), 32'((i % 2) == 0));
      chk($sformatf("frm.valid_in[%0d]", i), 32'(valid_in), 32'(!internal));
      chk($sformatf("frm.internal_valid[%0d]", i), 32'(internal_valid), 32'(internal));
      chk($sformatf("frm.detail[%0d]", i), 32'(valid_detailOut), 32'(((i % 2) == 0) && (i != 0)));
      chk($sformatf("frm.done[%0d]", i), 32'(done), 32'd0);
      if (valid_detailOut) strobes++;
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
    #1;
    chk("frm.flush_in_ready", 32'(in_ready), 32'd0);
    chk("frm.flush_detail", 32'(valid_detailOut), 32'd1);
    chk("frm.flush_zero_sel", 32'(zero_sel), 32'd1);
    chk("frm.flush_valid_in", 32'(valid_in | internal_valid), 32'd0);
    chk("frm.flush_done", 32'(done), 32'd0);
    if (valid_detailOut) strobes++;
    tick();
    chk("frm.done", 32'(done), 32'd1);
    chk("frm.frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    chk("frm.zero_sel_off", 32'(zero_sel), 32'd0);
    chk("frm.strobe_count", 32'(strobes), 32'(len / 2));
    tick();
    chk("frm.done_clear", 32'(done), 32'd0);
    chk("frm.busy_clear", 32'(busy), 32'd0);
    chk("frm.frame_cnt_hold", 32'(frame_cnt), 32'(exp_cnt));
  endtask

  task automatic bad_start(input int len);
    start     = 1'b1;
    frame_len = LEN_W'(len);
    tick();
    start = 1'b0;
    chk($sformatf("bad%0d.frame_err", len), 32'(frame_err), 32'd1);
    chk($sformatf("bad%0d.busy", len), 32'(busy), 32'd0);
    chk($sformatf("bad%0d.in_ready", len), 32'(in_ready), 32'd0);
    tick();
    chk($sformatf("bad%0d.frame_err_clear", len), 32'(frame_err), 32'd0);
    chk($sformatf("bad%0d.in_ready_still", len), 32'(in_ready), 32'd0);
    chk($sformatf("bad%0d.frame_cnt", len), 32'(frame_cnt), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    do_reset();
    chk_all_zero("reset");

    // Nominal frame, samples 10,20,30,40.
    run_frame(4, 1'b0, 1, -1);

    do_reset();
    bad_start(3);
    bad_start(0);

    // Bubble after the third sample aborts the frame.
    do_reset();
    start     = 1'b1;
    frame_len = LEN_W'(6);
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("bub.in_ready", 32'(in_ready), 32'd1);
    chk("bub.detail", 32'(valid_detailOut), 32'd0);
    tick();
    chk("bub.frame_err", 32'(frame_err), 32'd1);
    chk("bub.busy", 32'(busy), 32'd0);
    chk("bub.done", 32'(done), 32'd0);
    tick();
    chk("bub.frame_err_clear", 32'(frame_err), 32'd0);
    chk("bub.done_none", 32'(done), 32'd0);
    chk("bub.frame_cnt", 32'(frame_cnt), 32'd0);
    run_frame(2, 1'b0, 1, -1);

    // Internal loopback source.
    do_reset();
    run_frame(2, 1'b1, 1, -1);

    // Start pulsed mid-frame is ignored; frame keeps its latched length.
    do_reset();
    run_frame(8, 1'b0, 1, 3);

    // Reset mid-frame after the fifth sample.
    start     = 1'b1;
    frame_len = LEN_W'(8);
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      tick();
    end
    rst = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    tick();
    chk("rst_mid.done_hold", 32'(done), 32'd0);
    in_valid = 1'b0;
    rst      = 1'b0;
    tick();
    chk("rst_mid.done_after", 32'(done), 32'd0);
    chk("rst_mid.frame_err_after", 32'(frame_err), 32'd0);

    // Frame counter wrap with a 2-bit counter.
    do_reset();
    run_frame(2, 1'b0, 1, -1);
    run_frame(2, 1'b0, 2, -1);
    run_frame(2, 1'b0, 3, -1);
    run_frame(2, 1'b0, 0, -1);
    run_frame(2, 1'b0, 1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lifting_seq_ctrl.md
Name: lifting_seq_ctrl

Overview:
- Frame sequencer for the DWT lifting predictor stage.
- Accepts a contiguous sample stream under a ready/valid handshake and counts samples per frame.
- Drives the predictor's per-sample controls: sample valid, internal-source valid, even/odd phase and detail-output strobe.
- At frame end, inserts one zero-extension flush cycle so the last detail coefficient is emitted, then reports completion and frame statistics.

Parameters:
- LEN_W, 12, width of frame length and sample counter; max frame 2^LEN_W-2 samples.
- FRM_W, 8, width of completed-frame counter (wraps).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  one-cycle frame start request, honoured in IDLE only.
- frame_len  input  LEN_W  sample count for the frame, latched on accepted start.
- cfg_internal  input  1  latched on start; 1 = samples come from the internal loopback (next DWT level).
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  controller accepting samples.
- valid_in  output  1  to predictor valid_in: accept & ~cfg_internal_q.
- internal_valid  output  1  to predictor internal_valid: accept & cfg_internal_q.
- iseven  output  1  to predictor; phase of the current sample.
- valid_detailOut  output  1  to predictor; detail coefficient valid this cycle.
- zero_sel  output  1  forces the predictor data mux to 0 (flush cycle).
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse, frame completed.
- frame_err  output  1  one-cycle pulse, start rejected or frame aborted.
- frame_cnt  output  FRM_W  completed-frame count.

Behaviour:
- Reset (async, any state): state=IDLE, cnt=0. All 1-bit outputs are 0 and frame_cnt=0. Latched configuration is cleared.
- States and transitions:
  - IDLE: in_ready=0. On start:
    - frame_len even and >=2 -> latch frame_len and cfg_internal, cnt=0, go to RUN.
    - otherwise -> pulse frame_err the next cycle and stay in IDLE.
  - RUN:
    - in_ready=1; accept = in_valid & in_ready.
    - iseven = ~cnt[0]. This is combinational from the registered count and is valid whenever in_ready=1.
    - On accept, cnt increments.
    - valid_detailOut = accept & iseven & (cnt!=0). This is the same cycle as the even sample whose shifted value completes the previous pair.
    - After accepting sample cnt=len-1, go to FLUSH.
    - in_valid=0 during RUN is a bubble. The predictor clears its pipeline when idle, so a bubble aborts the frame: pulse frame_err, go to IDLE, frame_cnt unchanged.
  - FLUSH (exactly 1 cycle):
    - in_ready=0, valid_in=0, internal_valid=0, valid_detailOut=1, zero_sel=1.
    - The predictor emits d2-0 in this cycle.
    - Next state DONE.
  - DONE (1 cycle): done=1, frame_cnt+1 (wraps at 2^FRM_W), go to IDLE.
- start is ignored outside IDLE; no error is flagged.
- Detail strobes per frame are exactly len/2: (len/2-1) in RUN plus 1 in FLUSH.
- Latency:
  - start to in_ready = 1 cycle.
  - Last sample accept to FLUSH = 1 cycle.
  - FLUSH to done = 1 cycle.
  - A new start is accepted in the cycle done is high? No: only once state is IDLE, i.e. the cycle after done.
- frame_len changes after latching have no effect on the running frame.
- Reset asserted mid-frame: immediate return to IDLE with no done or frame_err pulse, and frame_cnt=0.
- All outputs are registered except in_ready, valid_in, internal_valid, iseven, valid_detailOut and zero_sel, which are decoded from state and count (plus in_valid for the strobes).

Test Plan:
- Nominal frame: start, len=4, cfg_internal=0, samples 10,20,30,40 back-to-back.
  - iseven must read 1,0,1,0.
  - valid_detailOut must be high on the accept of 30 (predictor detail=0) and in FLUSH (predictor detail=25), zero_sel=1 in FLUSH.
  - done must pulse 2 cycles after 40 is accepted; frame_cnt=1.
- Bad length: start with len=3, then len=0 -> frame_err pulse each time, state stays IDLE, in_ready stays 0, frame_cnt=0.
- Bubble abort: len=6, in_valid low for 1 cycle after the 3rd sample -> frame_err pulse, busy=0 next cycle, no done; a following len=2 frame completes with frame_cnt=1.
- Internal source: cfg_internal=1, len=2 -> internal_valid high on both accepts, valid_in stays 0; exactly 1 detail strobe, which occurs in FLUSH.
- Start while busy and reset mid-frame:
  - start pulsed in RUN (len=8) is ignored and the frame completes with 4 strobes.
  - rst asserted after the 5th sample -> all outputs 0 the same cycle, no done.
- Counter wrap: FRM_W=2, run 5 frames of len=2 -> frame_cnt sequence 1,2,3,0,1.
